// File: rtl/dff_pipe_chain_pkg.sv
// dff_pipe_chain_pkg
//   Shared defaults for the pipelined register chain. The stage module, the
//   bus interface and the chain top take their default parameter values from
//   here so that every piece of the slice agrees when left at defaults.
package dff_pipe_chain_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/dff_pipe_chain_if.sv
// dff_pipe_chain_if
//   Data bus of the register chain.
//   Handshake: valid-only, no ready. The producer (master) presents i_data
//   with i_valid; the chain never pushes back, so a word is accepted on every
//   enabled clock edge where i_valid=1. On the output side o_valid marks
//   o_data as meaningful; the consumer cannot stall it.
//   Signals:
//     i_valid, i_data          master -> chain  input word
//     o_valid, o_data          chain -> master  last stage
//     o_taps                   chain -> master  all stage data, stage 0 in the low bits
//     o_vtaps                  chain -> master  all stage valids, bit k = stage k
//     o_count                  chain -> master  number of valid stages
import dff_pipe_chain_pkg::*;

interface dff_pipe_chain_if #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();
    localparam int CW = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

    logic                   i_valid;
    logic [WIDTH-1:0]       i_data;
    logic                   o_valid;
    logic [WIDTH-1:0]       o_data;
    logic [DEPTH*WIDTH-1:0] o_taps;
    logic [DEPTH-1:0]       o_vtaps;
    logic [CW-1:0]          o_count;

    modport master (
        output i_valid, i_data,
        input  o_valid, o_data, o_taps, o_vtaps, o_count
    );

    modport slave (
        input  i_valid, i_data,
        output o_valid, o_data, o_taps, o_vtaps, o_count
    );
endinterface

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage
//   One stage of the chain: a WIDTH-bit data register plus its valid bit.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_clear          synchronous clear (wins over i_en)
//     i_en             advance enable; low = hold
//     i_valid, i_data  word from the previous stage (or the chain input)
//     o_valid, o_data  registered stage contents
//   The data register only loads when the incoming word is valid, so a
//   bubble leaves the previous data in place instead of zeroing it.
import dff_pipe_chain_pkg::*;

module dff_pipe_stage #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= RESET_VAL;
        end else if (i_clear) begin
            o_valid <= 1'b0;
            o_data  <= RESET_VAL;
        end else if (i_en) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe_chain.sv
// dff_pipe_chain
//   WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking, a
//   global stall enable, synchronous clear, stage taps and an occupancy
//   counter. A word accepted on an enabled edge reaches o_data after DEPTH
//   enabled edges (capture edge included); stalled cycles add latency 1:1.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_clear          synchronous clear, priority over i_en
//     i_en             advance enable; 0 freezes the whole chain
//     bus              dff_pipe_chain_if slave: input word, last stage,
//                      taps, valid taps and occupancy count
//   All outputs come straight from registers.
import dff_pipe_chain_pkg::*;

module dff_pipe_chain #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clear,
    input  logic           i_en,
    dff_pipe_chain_if.slave bus
);

    localparam int CW = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [CW-1:0]    count;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_data;

        if (k == 0) begin : g_head
            assign in_valid = bus.i_valid;
            assign in_data  = bus.i_data;
        end else begin : g_body
            assign in_valid = vld[k-1];
            assign in_data  = dat[k-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clear (i_clear),
            .i_en    (i_en),
            .i_valid (in_valid),
            .i_data  (in_data),
            .o_valid (vld[k]),
            .o_data  (dat[k])
        );

        assign bus.o_taps[k*WIDTH +: WIDTH] = dat[k];
    end

    // Occupancy tracks the valid bits incrementally: a word entering adds
    // one, a word leaving the last stage removes one, both cancel. This
    // keeps count equal to the number of set valid bits without an adder
    // tree, and it can never leave 0..DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_en) begin
            case ({bus.i_valid, vld[DEPTH-1]})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.o_valid = vld[DEPTH-1];
    assign bus.o_data  = dat[DEPTH-1];
    assign bus.o_vtaps = vld;
    assign bus.o_count = count;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// tb_dff_pipe_chain
//   Directed bench for dff_pipe_chain at WIDTH=8/DEPTH=4 with a second
//   DEPTH=1 instance fed the same stimulus. Inputs change on the falling
//   edge; outputs are sampled on the falling edge.
module tb_dff_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic i_clk;
    logic i_rst_n;
    logic i_clear;
    logic i_en;

    int n_checks;
    int n_errors;

    dff_pipe_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus4 ();
    dff_pipe_chain_if #(.WIDTH(WIDTH), .DEPTH(1))     bus1 ();

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) u_dut4 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_en    (i_en),
        .bus     (bus4.slave)
    );

    dff_pipe_chain #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_en    (i_en),
        .bus     (bus1.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Occupancy must always equal the number of valid stages.
    always @(negedge i_clk) begin
        check("inv_count4", 64'(bus4.o_count), 64'($countones(bus4.o_vtaps)));
        check("inv_count1", 64'(bus1.o_count), 64'($countones(bus1.o_vtaps)));
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic [WIDTH-1:0] d);
        bus4.i_valid = v;
        bus4.i_data  = d;
        bus1.i_valid = v;
        bus1.i_data  = d;
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_cnt;
        int lo;

        n_checks = 0;
        n_errors = 0;
        i_rst_n  = 1'b0;
        i_clear  = 1'b0;
        i_en     = 1'b0;
        drive(1'b0, 8'h00);

        step();
        step();
        check("rst_valid", 64'(bus4.o_valid), 64'd0);
        check("rst_data",  64'(bus4.o_data),  64'h00);
        check("rst_count", 64'(bus4.o_count), 64'd0);
        check("rst_taps",  64'(bus4.o_taps),  64'h0);
        i_rst_n = 1'b1;
        step();

        // --- latency: one word, appears after DEPTH enabled edges ---
        i_en = 1'b1;
        drive(1'b1, 8'hA5);
        step();
        drive(1'b0, 8'h00);
        check("lat_vtaps_e0", 64'(bus4.o_vtaps), 64'h1);
        check("lat_count_e0", 64'(bus4.o_count), 64'd1);
        check("d1_lat_valid", 64'(bus1.o_valid), 64'd1);
        check("d1_lat_data",  64'(bus1.o_data),  64'hA5);
        step();
        check("lat_vtaps_e1", 64'(bus4.o_vtaps), 64'h2);
        check("lat_count_e1", 64'(bus4.o_count), 64'd1);
        step();
        check("lat_valid_e2", 64'(bus4.o_valid), 64'd0);
        check("lat_count_e2", 64'(bus4.o_count), 64'd1);
        step();
        check("lat_valid_e3", 64'(bus4.o_valid), 64'd1);
        check("lat_data_e3",  64'(bus4.o_data),  64'hA5);
        check("lat_count_e3", 64'(bus4.o_count), 64'd1);
        step();
        check("lat_valid_e4", 64'(bus4.o_valid), 64'd0);
        check("lat_count_e4", 64'(bus4.o_count), 64'd0);
        check("lat_hold_e4",  64'(bus4.o_data),  64'hA5);

        // --- stream: 01..06 back to back, full is not backpressure ---
        for (int e = 1; e <= 10; e++) begin
            drive(e <= 6, 8'(e));
            step();
            exp_cnt = 0;
            lo = (e - 3 < 1) ? 1 : e - 3;
            for (int j = lo; j <= e; j++) begin
                if (j <= 6) exp_cnt++;
            end
            check("str_count", 64'(bus4.o_count), 64'(exp_cnt));
            check("str_valid", 64'(bus4.o_valid), 64'(e >= 4 && e <= 9));
            if (e >= 4 && e <= 9) begin
                check("str_data", 64'(bus4.o_data), 64'(e - 3));
            end
        end
        drive(1'b0, 8'h00);
        check("str_hold", 64'(bus4.o_data), 64'h06);

        // --- stall: 11,22 then 5 frozen cycles with FF on the input ---
        drive(1'b1, 8'h11);
        step();
        drive(1'b1, 8'h22);
        step();
        check("stl_taps_pre",  64'(bus4.o_taps),  64'h06061122);
        check("stl_count_pre", 64'(bus4.o_count), 64'd2);
        i_en = 1'b0;
        drive(1'b1, 8'hFF);
        for (int s = 0; s < 5; s++) begin
            step();
            check("stl_taps",  64'(bus4.o_taps),  64'h06061122);
            check("stl_vtaps", 64'(bus4.o_vtaps), 64'h3);
            check("stl_count", 64'(bus4.o_count), 64'd2);
        end
        i_en = 1'b1;
        drive(1'b0, 8'h00);
        step();
        check("stl_r1_taps",  64'(bus4.o_taps),  64'h06112222);
        check("stl_r1_valid", 64'(bus4.o_valid), 64'd0);
        step();
        check("stl_r2_valid", 64'(bus4.o_valid), 64'd1);
        check("stl_r2_data",  64'(bus4.o_data),  64'h11);
        step();
        check("stl_r3_data",  64'(bus4.o_data),  64'h22);
        check("stl_r3_count", 64'(bus4.o_count), 64'd1);
        step();
        check("stl_r4_valid", 64'(bus4.o_valid), 64'd0);
        check("stl_r4_count", 64'(bus4.o_count), 64'd0);

        // --- clear beats enable and valid on the same edge ---
        for (int w = 1; w <= 4; w++) begin
            drive(1'b1, 8'(8'hA0 + w));
            step();
        end
        check("clr_taps_pre",  64'(bus4.o_taps),  64'hA1A2A3A4);
        check("clr_count_pre", 64'(bus4.o_count), 64'd4);
        i_clear = 1'b1;
        drive(1'b1, 8'h5A);
        step();
        i_clear = 1'b0;
        drive(1'b0, 8'h00);
        check("clr_vtaps", 64'(bus4.o_vtaps), 64'h0);
        check("clr_taps",  64'(bus4.o_taps),  64'h0);
        check("clr_count", 64'(bus4.o_count), 64'd0);
        check("d1_clr_valid", 64'(bus1.o_valid), 64'd0);

        // --- bubbles: 3C, (77 not valid), C3 ---
        drive(1'b1, 8'h3C);
        step();
        check("bub_e1_taps", 64'(bus4.o_taps), 64'h0000003C);
        check("d1_bub_e1_valid", 64'(bus1.o_valid), 64'd1);
        check("d1_bub_e1_count", 64'(bus1.o_count), 64'd1);
        drive(1'b0, 8'h77);
        step();
        check("bub_e2_taps", 64'(bus4.o_taps), 64'h00003C3C);
        check("d1_bub_e2_valid", 64'(bus1.o_valid), 64'd0);
        check("d1_bub_e2_count", 64'(bus1.o_count), 64'd0);
        check("d1_bub_e2_data",  64'(bus1.o_data),  64'h3C);
        drive(1'b1, 8'hC3);
        step();
        drive(1'b0, 8'h00);
        check("bub_e3_vtaps", 64'(bus4.o_vtaps), 64'h5);
        check("bub_e3_taps",  64'(bus4.o_taps),  64'h003C3CC3);
        check("d1_bub_e3_data",  64'(bus1.o_data),  64'hC3);
        check("d1_bub_e3_count", 64'(bus1.o_count), 64'd1);
        step();
        check("bub_e4_vtaps", 64'(bus4.o_vtaps), 64'hA);
        check("bub_e4_data",  64'(bus4.o_data),  64'h3C);
        check("d1_bub_e4_count", 64'(bus1.o_count), 64'd0);
        step();
        check("bub_e5_valid", 64'(bus4.o_valid), 64'd0);
        check("bub_e5_data",  64'(bus4.o_data),  64'h3C);
        check("bub_e5_taps",  64'(bus4.o_taps),  64'h3CC3C3C3);
        step();
        check("bub_e6_valid", 64'(bus4.o_valid), 64'd1);
        check("bub_e6_data",  64'(bus4.o_data),  64'hC3);
        step();
        check("bub_e7_count", 64'(bus4.o_count), 64'd0);

        // --- async reset mid-cycle with the chain full ---
        for (int w = 1; w <= 4; w++) begin
            drive(1'b1, 8'(8'hB0 + w));
            step();
        end
        drive(1'b0, 8'h00);
        i_en = 1'b0;
        check("ar_count_pre", 64'(bus4.o_count), 64'd4);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus4.o_valid), 64'd0);
        check("ar_data",  64'(bus4.o_data),  64'h00);
        check("ar_count", 64'(bus4.o_count), 64'd0);
        check("ar_taps",  64'(bus4.o_taps),  64'h0);
        check("d1_ar_valid", 64'(bus1.o_valid), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        check("ar_after_count", 64'(bus4.o_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
